gmii_tx_sender: RTL and testbench
=================================

// Module: gmii_tx_sender
// PURPOSE
// Transmit-side counterpart of the GMII receive path. Drains frames the host writes over PCIe into the
// TX0 frame memory (tracked by tx0mem_wr_ptr) and serialises them onto the PHY GMII transmit pins:
// preamble, SFD, payload, optional FCS, then inter-frame gap. Sits between the TX0 memory read port and
// phy1_tx_data/phy1_tx_en in ethpipe_mid; all logic runs in the 125 MHz GMII transmit clock domain.
// PARAMETERS
// ADDR_W     12    word-address width of the frame memory (16-bit words; pointers wrap mod 2**ADDR_W)
// IFG_BYTES  12    idle cycles forced after every transmitted frame
// MIN_LEN    14    smallest legal length field, bytes
// MAX_LEN    1518  largest legal length field, bytes (1514 when TX_CRC_APPEND_EN is defined)
// PORTS
// sys_clk       in   1       125 MHz clock (GMII tx clock)
// sys_rst       in   1       asynchronous, active-high reset
// tx_enable     in   1       permits starting a new frame; a frame already in progress always completes
// wr_ptr        in   ADDR_W  host write pointer: first word not yet written
// rd_ptr        out  ADDR_W  read pointer: first word of the next unsent frame
// mem_rd_addr   out  ADDR_W  registered memory read address
// mem_rd_data   in   16      memory data, valid exactly 1 cycle after mem_rd_addr
// gmii_txd      out  8       GMII transmit data
// gmii_tx_en    out  1       GMII transmit enable
// busy          out  1       high in every state except IDLE
// tx_frame_cnt  out  32      frames fully transmitted (wraps)
// tx_err_cnt    out  16      frames dropped for an illegal length (saturates at 0xFFFF)
// BEHAVIOUR
// - Reset: every output is 0 (rd_ptr, mem_rd_addr, gmii_txd, gmii_tx_en, busy, counters); state IDLE.
//   Reset asserted mid-frame drops gmii_tx_en immediately; the truncated frame is not resent.
// - Memory frame format: word rd_ptr = length L in bytes (bits[10:0]; bits[15:11] must be 0), followed by
//   ceil(L/2) data words. Byte order within a word: [15:8] first, then [7:0]; the pad byte of odd L is ignored.
// - FSM IDLE -> LEN_RD -> LEN_CHK -> PREAMBLE -> DATA [-> FCS] -> IFG -> IDLE.
//   IDLE: when tx_enable=1 and rd_ptr!=wr_ptr, mem_rd_addr<=rd_ptr; go to LEN_RD.
//   LEN_RD: mem_rd_addr<=rd_ptr+1; go to LEN_CHK.
//   LEN_CHK: latch L. Illegal (L<MIN_LEN, L>MAX_LEN, or bits[15:11]!=0): rd_ptr<=wr_ptr (flush),
//     tx_err_cnt+1, go to IDLE with gmii_tx_en held at 0. Legal: go to PREAMBLE.
//   PREAMBLE: 8 cycles, gmii_tx_en=1, txd=0x55 x7 then 0xD5. The first data word is prefetched here.
//   DATA: one byte per cycle for exactly L cycles. The next word is fetched every 2nd cycle, one word ahead.
//   FCS: 4 cycles (only when the macro is defined). IFG: IFG_BYTES cycles with gmii_tx_en=0, txd=0x00.
//     On entry to IFG: rd_ptr<=rd_ptr+1+ceil(L/2) and tx_frame_cnt+1.
// - Latency: the first 0x55 appears on gmii_tx_en/gmii_txd 3 cycles after the IDLE cycle that sees work.
//   Back-to-back frames are separated by exactly IFG_BYTES+3 idle cycles.
// - All address arithmetic is mod 2**ADDR_W. Frames may straddle the wrap point; data reads wrap with them.
// - wr_ptr is sampled only in IDLE and LEN_CHK. Host writes during a frame never disturb it.
//   rd_ptr==wr_ptr means empty; the host never fills the last word.
// - gmii_txd is 0x00 whenever gmii_tx_en=0. Both are registered outputs.
// CONFIGURATION
// - TX_CRC_APPEND_EN defined: IEEE 802.3 CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, output
//   complemented) over the L data bytes, sent LSB-byte first in FCS state; MAX_LEN check uses 1514.
// - Undefined: no CRC logic and no FCS state; the host supplies the FCS inside L; MAX_LEN check uses 1518.
// TESTING
// 1. L=0x003C at word 0x000, data bytes 0x00..0x3B, wr_ptr 0x000->0x01F -> 0x55 x7, 0xD5, bytes 00..3B
//    (+4 FCS bytes matching the model if enabled); rd_ptr=0x01F; tx_frame_cnt=1.
// 2. Odd L=0x003D -> 61 data bytes, pad byte not sent, rd_ptr advances by 0x020.
// 3. Frame at 0xFF0, L=60, wr_ptr=0x00F -> correct bytes across the wrap; rd_ptr=0x00F.
// 4. L=0x0800 at 0x000, wr_ptr=0x040 -> gmii_tx_en never asserted; rd_ptr=0x040; tx_err_cnt=1; busy back to 0.
// 5. Two 60-byte frames queued together -> exactly IFG_BYTES+3 low cycles between them; tx_frame_cnt=2.
//    tx_enable=0 before the 2nd frame -> the 2nd frame is held until tx_enable=1.
// 6. sys_rst pulsed at DATA byte 20 -> gmii_tx_en=0 during reset; rd_ptr=0; after release, frame resent from 0x000.

Source files
------------

// File: rtl/gmii_tx_sender.sv
// gmii_tx_sender: drains length-prefixed frames from the TX0 frame memory and
// serialises them onto the GMII transmit pins: 7x 0x55 preamble, 0xD5 SFD,
// L payload bytes, an optional 4-byte FCS, then a forced inter-frame gap.
// Optional feature: define TX_CRC_APPEND_EN to generate and append the
// IEEE 802.3 CRC-32 FCS in hardware (the legal length limit drops by 4).
module gmii_tx_sender #(
    parameter int ADDR_W    = 12,
    parameter int IFG_BYTES = 12,
    parameter int MIN_LEN   = 14,
    parameter int MAX_LEN   = 1518
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              tx_enable,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [15:0]       mem_rd_data,
    output logic [7:0]        gmii_txd,
    output logic              gmii_tx_en,
    output logic              busy,
    output logic [31:0]       tx_frame_cnt,
    output logic [15:0]       tx_err_cnt
);

`ifdef TX_CRC_APPEND_EN
    localparam int LEN_LIMIT = MAX_LEN - 4;
`else
    localparam int LEN_LIMIT = MAX_LEN;
`endif

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] LIM_L    = 11'(LEN_LIMIT);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LEN_RD   = 3'd1,
        S_LEN_CHK  = 3'd2,
        S_PREAMBLE = 3'd3,
        S_DATA     = 3'd4,
        S_IFG      = 3'd5
`ifdef TX_CRC_APPEND_EN
        , S_FCS    = 3'd6
`endif
    } state_t;

    state_t            state, state_n;
    logic [10:0]       cnt, cnt_n;
    logic [10:0]       frame_len, len_n;
    logic [15:0]       word_buf, word_n;
    logic [ADDR_W-1:0] rd_ptr_n, addr_n;
    logic [7:0]        txd_n;
    logic              tx_en_n;
    logic [31:0]       frame_cnt_n;
    logic [15:0]       err_cnt_n;
    logic              len_ok;
    logic [11:0]       half_words;
    logic [ADDR_W-1:0] next_frame_ptr;

`ifdef TX_CRC_APPEND_EN
    logic [31:0] crc, crc_n;
    logic [23:0] fcs_sr, fcs_n;

    // Reflected CRC-32 update by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[i])
                c = (c >> 1) ^ 32'hEDB88320;
            else
                c = c >> 1;
        end
        return c;
    endfunction
`endif

    assign busy = (state != S_IDLE);

    // Length word legality and the pointer to the frame after this one.
    assign len_ok = (mem_rd_data[15:11] == 5'd0) &&
                    (mem_rd_data[10:0] >= MIN_L) &&
                    (mem_rd_data[10:0] <= LIM_L);
    assign half_words     = (12'(frame_len) + 12'd1) >> 1;
    assign next_frame_ptr = rd_ptr + ADDR_W'(1) + ADDR_W'(half_words);

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Datapath and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt          <= '0;
            frame_len    <= '0;
            word_buf     <= '0;
            rd_ptr       <= '0;
            mem_rd_addr  <= '0;
            gmii_txd     <= '0;
            gmii_tx_en   <= 1'b0;
            tx_frame_cnt <= '0;
            tx_err_cnt   <= '0;
`ifdef TX_CRC_APPEND_EN
            crc          <= '1;
            fcs_sr       <= '0;
`endif
        end else begin
            cnt          <= cnt_n;
            frame_len    <= len_n;
            word_buf     <= word_n;
            rd_ptr       <= rd_ptr_n;
            mem_rd_addr  <= addr_n;
            gmii_txd     <= txd_n;
            gmii_tx_en   <= tx_en_n;
            tx_frame_cnt <= frame_cnt_n;
            tx_err_cnt   <= err_cnt_n;
`ifdef TX_CRC_APPEND_EN
            crc          <= crc_n;
            fcs_sr       <= fcs_n;
`endif
        end
    end

    // Next state and next register values. The output registers are loaded
    // one cycle ahead, so each state computes the byte shown in the next one;
    // the state label names what is currently on the pins.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        len_n       = frame_len;
        word_n      = word_buf;
        rd_ptr_n    = rd_ptr;
        addr_n      = mem_rd_addr;
        txd_n       = 8'h00;
        tx_en_n     = 1'b0;
        frame_cnt_n = tx_frame_cnt;
        err_cnt_n   = tx_err_cnt;
`ifdef TX_CRC_APPEND_EN
        crc_n       = crc;
        fcs_n       = fcs_sr;
`endif
        case (state)
            S_IDLE: begin
                if (tx_enable && (rd_ptr != wr_ptr)) begin
                    addr_n  = rd_ptr;
                    state_n = S_LEN_RD;
                end
            end
            S_LEN_RD: begin
                addr_n  = rd_ptr + ADDR_W'(1);
                state_n = S_LEN_CHK;
            end
            S_LEN_CHK: begin
                if (len_ok) begin
                    len_n   = mem_rd_data[10:0];
                    cnt_n   = '0;
                    tx_en_n = 1'b1;
                    txd_n   = 8'h55;
                    state_n = S_PREAMBLE;
`ifdef TX_CRC_APPEND_EN
                    crc_n   = '1;
`endif
                end else begin
                    rd_ptr_n  = wr_ptr;
                    err_cnt_n = (tx_err_cnt == 16'hFFFF) ? tx_err_cnt : tx_err_cnt + 16'd1;
                    state_n   = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                tx_en_n = 1'b1;
                cnt_n   = cnt + 11'd1;
                // Word 0 has been on mem_rd_data since this state began.
                if (cnt == 11'd0) begin
                    word_n = mem_rd_data;
                    addr_n = mem_rd_addr + ADDR_W'(1);
                end
                if (cnt == 11'd7) begin
                    txd_n   = word_buf[15:8];
                    cnt_n   = '0;
                    state_n = S_DATA;
`ifdef TX_CRC_APPEND_EN
                    crc_n   = crc32_byte(crc, word_buf[15:8]);
`endif
                end else if (cnt == 11'd6) begin
                    txd_n = 8'hD5;
                end else begin
                    txd_n = 8'h55;
                end
            end
            S_DATA: begin
                if (cnt == frame_len - 11'd1) begin
`ifdef TX_CRC_APPEND_EN
                    tx_en_n = 1'b1;
                    txd_n   = ~crc[7:0];
                    fcs_n   = ~crc[31:8];
                    cnt_n   = '0;
                    state_n = S_FCS;
`else
                    cnt_n       = '0;
                    rd_ptr_n    = next_frame_ptr;
                    frame_cnt_n = tx_frame_cnt + 32'd1;
                    state_n     = S_IFG;
`endif
                end else begin
                    tx_en_n = 1'b1;
                    cnt_n   = cnt + 11'd1;
                    // Low byte goes out on even counts; the word fetched one
                    // ahead is captured at the same time and the address moves on.
                    if (!cnt[0]) begin
                        txd_n  = word_buf[7:0];
                        word_n = mem_rd_data;
                        addr_n = mem_rd_addr + ADDR_W'(1);
                    end else begin
                        txd_n = word_buf[15:8];
                    end
`ifdef TX_CRC_APPEND_EN
                    crc_n = crc32_byte(crc, txd_n);
`endif
                end
            end
`ifdef TX_CRC_APPEND_EN
            S_FCS: begin
                if (cnt == 11'd3) begin
                    cnt_n       = '0;
                    rd_ptr_n    = next_frame_ptr;
                    frame_cnt_n = tx_frame_cnt + 32'd1;
                    state_n     = S_IFG;
                end else begin
                    tx_en_n = 1'b1;
                    txd_n   = fcs_sr[7:0];
                    fcs_n   = fcs_sr >> 8;
                    cnt_n   = cnt + 11'd1;
                end
            end
`endif
            S_IFG: begin
                cnt_n = cnt + 11'd1;
                if (cnt == IFG_LAST)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gmii_tx_sender.sv
// Self-checking bench for gmii_tx_sender: a synchronous-read frame memory,
// a GMII monitor that splits the pin stream into frames, and a byte-level
// reference model built from the frame contents written into memory.
`timescale 1ns/1ps
module tb_gmii_tx_sender;

    localparam int ADDR_W    = 12;
    localparam int IFG_BYTES = 12;
    localparam int MIN_LEN   = 14;
    localparam int MAX_LEN   = 1518;
`ifdef TX_CRC_APPEND_EN
    localparam int LIMIT = MAX_LEN - 4;
    localparam int FCS_N = 4;
`else
    localparam int LIMIT = MAX_LEN;
    localparam int FCS_N = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        tx_enable;
    logic [11:0] wr_ptr;
    logic [11:0] rd_ptr;
    logic [11:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        busy;
    logic [31:0] tx_frame_cnt;
    logic [15:0] tx_err_cnt;

    gmii_tx_sender #(
        .ADDR_W(ADDR_W), .IFG_BYTES(IFG_BYTES), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_enable(tx_enable),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .busy(busy), .tx_frame_cnt(tx_frame_cnt), .tx_err_cnt(tx_err_cnt)
    );

    always #4 sys_clk = ~sys_clk;

    // Frame memory: data valid one cycle after the address.
    logic [15:0] mem [0:4095];
    always @(posedge sys_clk) mem_rd_data <= mem[mem_rd_addr];

    // Monitor: collects bytes while gmii_tx_en is high, logs complete frames,
    // measures idle runs between frames, and flags non-zero txd while idle.
    byte unsigned rx_q[$];
    byte unsigned cur_q[$];
    int           rx_len_q[$];
    int           gap_q[$];
    int           low_run = 0;
    int           en_cycles = 0;
    int           idle_nonzero = 0;
    bit           prev_en = 1'b0;
    bit           seen = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            cur_q.delete();
            prev_en = 1'b0;
            seen    = 1'b0;
            low_run = 0;
        end else begin
            if (gmii_tx_en) begin
                if (!prev_en && seen) gap_q.push_back(low_run);
                cur_q.push_back(gmii_txd);
                en_cycles++;
            end else begin
                if (gmii_txd !== 8'h00) idle_nonzero++;
                if (prev_en) begin
                    foreach (cur_q[i]) rx_q.push_back(cur_q[i]);
                    rx_len_q.push_back(cur_q.size());
                    cur_q.delete();
                    seen    = 1'b1;
                    low_run = 0;
                end
                low_run++;
            end
            prev_en = gmii_tx_en;
        end
    end

    // Reference model state.
    byte unsigned exp_q[$];
    int           exp_len_q[$];
    logic [11:0]  ptr, nxt, nxt2, nxt3;
    int           exp_frames, exp_errs;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Writes a frame of len bytes at base, queues its expected GMII bytes.
    task automatic load_frame(input logic [11:0] base, input int len, input bit rnd,
                              output logic [11:0] next_ptr);
        byte unsigned pl[$];
        logic [7:0]   hi, lo;
`ifdef TX_CRC_APPEND_EN
        logic [31:0]  c;
`endif
        mem[base] = 16'(len);
        for (int i = 0; i < len; i++) pl.push_back(rnd ? 8'($urandom) : 8'(i));
        for (int k = 0; k < (len + 1) / 2; k++) begin
            hi = pl[2*k];
            if (2*k + 1 < len) lo = pl[2*k + 1];
            else               lo = 8'($urandom_range(1, 255));
            mem[12'(base + 12'(1 + k))] = {hi, lo};
        end
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pl[i]) exp_q.push_back(pl[i]);
`ifdef TX_CRC_APPEND_EN
        c = '1;
        foreach (pl[i]) begin
            c ^= 32'(pl[i]);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8*i)));
`endif
        exp_len_q.push_back(8 + len + FCS_N);
        next_ptr = 12'(base + 12'(1 + (len + 1) / 2));
    endtask

    task automatic wait_ptr(input string tag, input logic [11:0] target, input int limit);
        int n;
        n = 0;
        while (!(!busy && rd_ptr == target) && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, " completion"}, 32'(n < limit), 32'd1);
    endtask

    task automatic check_frames(input string tag);
        int bad, first, len_bad;
        check({tag, " frame count"}, 32'(rx_len_q.size()), 32'(exp_len_q.size()));
        check({tag, " byte count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        len_bad = 0;
        for (int i = 0; i < rx_len_q.size() && i < exp_len_q.size(); i++)
            if (rx_len_q[i] != exp_len_q[i]) len_bad++;
        check({tag, " frame lengths"}, 32'(len_bad), 32'd0);
        bad   = 0;
        first = -1;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] != exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (first >= 0) check({tag, " first bad byte"}, 32'(rx_q[first]), 32'(exp_q[first]));
        check({tag, " byte errors"}, 32'(bad), 32'd0);
        rx_q.delete(); exp_q.delete(); rx_len_q.delete(); exp_len_q.delete();
    endtask

    // Illegal length word at ptr; the host pointer sits skip words further on.
    task automatic send_bad(input string tag, input logic [15:0] word, input int skip);
        int e0;
        e0 = en_cycles;
        mem[ptr] = word;
        nxt = 12'(ptr + 12'(skip));
        @(negedge sys_clk);
        wr_ptr = nxt;
        wait_ptr(tag, nxt, 60);
        exp_errs++;
        ptr = nxt;
        check({tag, " rd_ptr"}, 32'(rd_ptr), 32'(ptr));
        check({tag, " err_cnt"}, 32'(tx_err_cnt), 32'(exp_errs));
        check({tag, " tx_en never"}, 32'(en_cycles - e0), 32'd0);
    endtask

    task automatic send_good(input string tag, input int len);
        load_frame(ptr, len, 1'b1, nxt);
        @(negedge sys_clk);
        wr_ptr = nxt;
        wait_ptr(tag, nxt, len + 200);
        exp_frames++;
        ptr = nxt;
        check({tag, " rd_ptr"}, 32'(rd_ptr), 32'(ptr));
        check({tag, " frame_cnt"}, 32'(tx_frame_cnt), 32'(exp_frames));
        check_frames(tag);
    endtask

    initial begin
        int lat, e0, n, fc0;
        foreach (mem[i]) mem[i] = '0;
        sys_rst   = 1'b1;
        tx_enable = 1'b0;
        wr_ptr    = '0;
        repeat (3) @(negedge sys_clk);

        // Reset state.
        check("reset rd_ptr", 32'(rd_ptr), 32'd0);
        check("reset mem_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("reset gmii_txd", 32'(gmii_txd), 32'd0);
        check("reset gmii_tx_en", 32'(gmii_tx_en), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_cnt", tx_frame_cnt, 32'd0);
        check("reset err_cnt", 32'(tx_err_cnt), 32'd0);

        sys_rst    = 1'b0;
        tx_enable  = 1'b1;
        ptr        = '0;
        exp_frames = 0;
        exp_errs   = 0;

        // 60-byte counting pattern at word 0, with start latency.
        load_frame(ptr, 60, 1'b0, nxt);
        @(negedge sys_clk);
        wr_ptr = nxt;
        lat = 0;
        while (!gmii_tx_en && lat < 20) begin
            @(negedge sys_clk);
            lat++;
        end
        check("t1 start latency", 32'(lat), 32'd3);
        check("t1 busy", 32'(busy), 32'd1);
        wait_ptr("t1", nxt, 300);
        exp_frames++;
        ptr = nxt;
        check("t1 rd_ptr", 32'(rd_ptr), 32'h01F);
        check("t1 frame_cnt", tx_frame_cnt, 32'd1);
        check_frames("t1");

        // Odd length: pad byte dropped, pointer advances by 0x20.
        send_good("t2 odd", 61);
        check("t2 rd_ptr", 32'(rd_ptr), 32'h03F);

        // Flush to 0xFF0 with a too-short length word.
        send_bad("short flush", 16'h0005, 12'hFF0 - 12'h03F);
        check("flush rd_ptr", 32'(rd_ptr), 32'hFF0);

        // Frame straddling the address wrap.
        send_good("t3 wrap", 60);
        check("t3 rd_ptr", 32'(rd_ptr), 32'h00F);

        // Two frames queued together: gap between them.
        load_frame(ptr, 60, 1'b1, nxt);
        load_frame(nxt, 60, 1'b1, nxt2);
        @(negedge sys_clk);
        wr_ptr = nxt2;
        wait_ptr("t5 pair", nxt2, 600);
        exp_frames += 2;
        ptr = nxt2;
        check("t5 gap", 32'(gap_q[$]), 32'(IFG_BYTES + 3));
        check("t5 frame_cnt", tx_frame_cnt, 32'(exp_frames));
        check("t5 rd_ptr", 32'(rd_ptr), 32'(ptr));
        check_frames("t5");

        // tx_enable dropped during the first frame holds the second one.
        load_frame(ptr, $urandom_range(MIN_LEN, 80), 1'b1, nxt);
        load_frame(nxt, $urandom_range(MIN_LEN, 80), 1'b1, nxt2);
        @(negedge sys_clk);
        wr_ptr = nxt2;
        n = 0;
        while (!gmii_tx_en && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        tx_enable = 1'b0;
        wait_ptr("hold first", nxt, 300);
        e0 = en_cycles;
        repeat (40) @(negedge sys_clk);
        exp_frames++;
        check("hold rd_ptr", 32'(rd_ptr), 32'(nxt));
        check("hold busy", 32'(busy), 32'd0);
        check("hold no tx", 32'(en_cycles - e0), 32'd0);
        check("hold frames seen", 32'(rx_len_q.size()), 32'd1);
        check("hold frame_cnt", tx_frame_cnt, 32'(exp_frames));
        tx_enable = 1'b1;
        wait_ptr("hold second", nxt2, 300);
        exp_frames++;
        ptr = nxt2;
        check("hold2 frame_cnt", tx_frame_cnt, 32'(exp_frames));
        check_frames("hold");

        // Length boundaries.
        send_good("min len", MIN_LEN);
        send_bad("below min", 16'(MIN_LEN - 1), 20);
        send_bad("above max", 16'(LIMIT + 1), 5);
        send_bad("upper bits", 16'h083C, 31);
        send_good("max len", LIMIT);

        // Random legal lengths queued together.
        load_frame(ptr, $urandom_range(MIN_LEN, 200), 1'b1, nxt);
        load_frame(nxt, $urandom_range(MIN_LEN, 200), 1'b1, nxt2);
        load_frame(nxt2, $urandom_range(MIN_LEN, 200), 1'b1, nxt3);
        @(negedge sys_clk);
        wr_ptr = nxt3;
        wait_ptr("random trio", nxt3, 1200);
        exp_frames += 3;
        ptr = nxt3;
        check("trio rd_ptr", 32'(rd_ptr), 32'(ptr));
        check("trio frame_cnt", tx_frame_cnt, 32'(exp_frames));
        check_frames("trio");

        // Reset in the middle of a frame; the host pointer stays, so it resends.
        @(negedge sys_clk);
        sys_rst = 1'b1;
        wr_ptr  = '0;
        repeat (2) @(negedge sys_clk);
        load_frame(12'h000, 60, 1'b1, nxt);
        sys_rst = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        @(negedge sys_clk);
        wr_ptr = nxt;
        e0 = en_cycles;
        n  = 0;
        while (en_cycles - e0 < 28 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("t6 reached byte 20", 32'(n < 200), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6 tx_en in reset", 32'(gmii_tx_en), 32'd0);
        check("t6 rd_ptr in reset", 32'(rd_ptr), 32'd0);
        check("t6 busy in reset", 32'(busy), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_ptr("t6 resend", nxt, 300);
        exp_frames++;
        check("t6 rd_ptr", 32'(rd_ptr), 32'h01F);
        check("t6 frame_cnt", tx_frame_cnt, 32'(exp_frames));
        check_frames("t6");

        // Oversize length word 0x0800 at word 0 after reset.
        @(negedge sys_clk);
        sys_rst  = 1'b1;
        mem[0]   = 16'h0800;
        wr_ptr   = 12'h040;
        repeat (2) @(negedge sys_clk);
        fc0 = en_cycles;
        sys_rst = 1'b0;
        wait_ptr("t4 flush", 12'h040, 60);
        check("t4 rd_ptr", 32'(rd_ptr), 32'h040);
        check("t4 err_cnt", 32'(tx_err_cnt), 32'd1);
        check("t4 tx_en never", 32'(en_cycles - fc0), 32'd0);
        check("t4 busy", 32'(busy), 32'd0);
        check("t4 frame_cnt", tx_frame_cnt, 32'd0);

        check("txd zero while idle", 32'(idle_nonzero), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
